// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment shift-register chain driver:
// FSM encoding, clock-divider helper and segment-byte layout.
package seg7_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SHIFT_LO = 2'd1,
    ST_SHIFT_HI = 2'd2,
    ST_LATCH    = 2'd3
  } state_t;

  localparam int SEG_BITS = 8;
  localparam int SEG_DP   = 7;

  // System cycles per half shift-clock period.
  function automatic int calc_div(input int sys_hz, input int shift_hz);
    return sys_hz / (2 * shift_hz);
  endfunction

endpackage

// File: rtl/seg7_serial_chain_shift_tick_gen.sv
// Half-period tick generator: one-cycle tick every DIV cycles,
// restartable by a synchronous clear so ticks align to frame start.
module shift_tick_gen
  import seg7_pkg::*;
#(
  parameter int DIV = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clr,
  output logic o_tick
);

  localparam int CW = $clog2(DIV + 1);

  logic [CW-1:0] r_cnt;
  logic          w_tick;

  assign w_tick = (r_cnt == CW'(DIV - 1));
  assign o_tick = w_tick;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clr || w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/seg7_serial_chain.sv
// Serial driver for a chain of 74HC595-style 7-segment registers, with a
// one-deep pending frame buffer and an enable-driven abort path.
module seg7_serial_chain
  import seg7_pkg::*;
#(
  parameter int SYS_CLK_HZ    = 5_000_000,
  parameter int SHIFT_CLK_HZ  = 1_000_000,
  parameter int NUM_DIGITS    = 6,
  parameter int MSB_FIRST     = 1,
  parameter int LATCH_PERIODS = 1,
  parameter int INVERT_DATA   = 0
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_en,
  input  logic                    i_start_stb,
  input  logic [8*NUM_DIGITS-1:0] i_frame,
  output logic                    o_busy,
  output logic                    o_done_stb,
  output logic                    o_serial_data,
  output logic                    o_serial_clk,
  output logic                    o_serial_latch
);

  localparam int   DIV        = calc_div(SYS_CLK_HZ, SHIFT_CLK_HZ);
  localparam int   TOTAL_BITS = SEG_BITS * NUM_DIGITS;
  localparam int   BCW        = $clog2(TOTAL_BITS + 1);
  localparam int   LCW        = $clog2(2 * LATCH_PERIODS + 1);
  localparam logic IDLE_LVL   = (INVERT_DATA != 0);

  if (DIV < 1) begin : g_bad_div
    $error("seg7_serial_chain: SYS_CLK_HZ/(2*SHIFT_CLK_HZ) must be >= 1");
  end
  if (LATCH_PERIODS < 1) begin : g_bad_latch
    $error("seg7_serial_chain: LATCH_PERIODS must be >= 1");
  end

  function automatic logic first_bit(input logic [TOTAL_BITS-1:0] v);
    return ((MSB_FIRST != 0) ? v[TOTAL_BITS-1] : v[0]) ^ IDLE_LVL;
  endfunction

  function automatic logic [TOTAL_BITS-1:0] advance(input logic [TOTAL_BITS-1:0] v);
    return (MSB_FIRST != 0) ? (v << 1) : (v >> 1);
  endfunction

  state_t                r_state, w_state_next;
  logic [TOTAL_BITS-1:0] r_shift, w_shift_next;
  logic [TOTAL_BITS-1:0] r_pend, w_pend_next;
  logic                  r_pend_vld, w_pend_vld_next;
  logic [BCW-1:0]        r_bit_cnt, w_bit_cnt_next;
  logic [LCW-1:0]        r_latch_cnt, w_latch_cnt_next;
  logic                  r_busy, w_busy_next;
  logic                  r_done, w_done_next;
  logic                  r_sdata, w_sdata_next;
  logic                  r_sclk, w_sclk_next;
  logic                  r_latch, w_latch_next;
  logic                  w_tick, w_tick_clr;
  logic [TOTAL_BITS-1:0] w_shifted;
  logic [TOTAL_BITS-1:0] w_chain_frame;

  assign w_shifted     = advance(r_shift);
  // A start landing in the latch-exit cycle with nothing pending chains directly.
  assign w_chain_frame = r_pend_vld ? r_pend : i_frame;

  shift_tick_gen #(.DIV(DIV)) u_tick (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clr   (w_tick_clr),
    .o_tick  (w_tick)
  );

  always_comb begin
    w_state_next     = r_state;
    w_shift_next     = r_shift;
    w_pend_next      = r_pend;
    w_pend_vld_next  = r_pend_vld;
    w_bit_cnt_next   = r_bit_cnt;
    w_latch_cnt_next = r_latch_cnt;
    w_busy_next      = r_busy;
    w_done_next      = 1'b0;
    w_sdata_next     = r_sdata;
    w_sclk_next      = r_sclk;
    w_latch_next     = r_latch;
    w_tick_clr       = 1'b0;

    if (!i_en) begin
      w_state_next    = ST_IDLE;
      w_pend_vld_next = 1'b0;
      w_busy_next     = 1'b0;
      w_sdata_next    = IDLE_LVL;
      w_sclk_next     = 1'b0;
      w_latch_next    = 1'b0;
      w_tick_clr      = 1'b1;
    end else begin
      if (i_start_stb && (r_state != ST_IDLE)) begin
        w_pend_next     = i_frame;
        w_pend_vld_next = 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (i_start_stb) begin
            w_shift_next   = i_frame;
            w_bit_cnt_next = BCW'(TOTAL_BITS);
            w_sdata_next   = first_bit(i_frame);
            w_busy_next    = 1'b1;
            w_tick_clr     = 1'b1;
            w_state_next   = ST_SHIFT_LO;
          end
        end
        ST_SHIFT_LO: begin
          if (w_tick) begin
            w_sclk_next  = 1'b1;
            w_state_next = ST_SHIFT_HI;
          end
        end
        ST_SHIFT_HI: begin
          if (w_tick) begin
            w_sclk_next    = 1'b0;
            w_bit_cnt_next = r_bit_cnt - BCW'(1);
            if (r_bit_cnt == BCW'(1)) begin
              w_latch_next     = 1'b1;
              w_latch_cnt_next = LCW'(2 * LATCH_PERIODS - 1);
              w_state_next     = ST_LATCH;
            end else begin
              w_shift_next = w_shifted;
              w_sdata_next = first_bit(w_shifted);
              w_state_next = ST_SHIFT_LO;
            end
          end
        end
        ST_LATCH: begin
          if (w_tick) begin
            if (r_latch_cnt == '0) begin
              w_latch_next = 1'b0;
              w_done_next  = 1'b1;
              if (r_pend_vld || i_start_stb) begin
                w_shift_next    = w_chain_frame;
                w_bit_cnt_next  = BCW'(TOTAL_BITS);
                w_sdata_next    = first_bit(w_chain_frame);
                w_pend_vld_next = r_pend_vld && i_start_stb;
                w_state_next    = ST_SHIFT_LO;
              end else begin
                w_busy_next  = 1'b0;
                w_sdata_next = IDLE_LVL;
                w_state_next = ST_IDLE;
              end
            end else begin
              w_latch_cnt_next = r_latch_cnt - LCW'(1);
            end
          end
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_shift     <= '0;
      r_pend      <= '0;
      r_pend_vld  <= 1'b0;
      r_bit_cnt   <= '0;
      r_latch_cnt <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_sdata     <= IDLE_LVL;
      r_sclk      <= 1'b0;
      r_latch     <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_shift     <= w_shift_next;
      r_pend      <= w_pend_next;
      r_pend_vld  <= w_pend_vld_next;
      r_bit_cnt   <= w_bit_cnt_next;
      r_latch_cnt <= w_latch_cnt_next;
      r_busy      <= w_busy_next;
      r_done      <= w_done_next;
      r_sdata     <= w_sdata_next;
      r_sclk      <= w_sclk_next;
      r_latch     <= w_latch_next;
    end
  end

  assign o_busy         = r_busy;
  assign o_done_stb     = r_done;
  assign o_serial_data  = r_sdata;
  assign o_serial_clk   = r_sclk;
  assign o_serial_latch = r_latch;

endmodule

// File: tb/tb_seg7_serial_chain.sv
// Directed bench: a 6-digit MSB-first chain and a 1-digit LSB-first inverted
// chain, both at DIV=2, checked against hand-computed timing and bit streams.
module tb_seg7_serial_chain;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        a_en, a_start;
  logic [47:0] a_frame;
  logic        a_busy, a_done, a_data, a_sclk, a_latch;
  logic        b_en, b_start;
  logic [7:0]  b_frame;
  logic        b_busy, b_done, b_data, b_sclk, b_latch;

  seg7_serial_chain #(
    .SYS_CLK_HZ(4), .SHIFT_CLK_HZ(1), .NUM_DIGITS(6),
    .MSB_FIRST(1), .LATCH_PERIODS(1), .INVERT_DATA(0)
  ) dut_a (
    .i_clk(clk), .i_reset(rst), .i_en(a_en), .i_start_stb(a_start),
    .i_frame(a_frame), .o_busy(a_busy), .o_done_stb(a_done),
    .o_serial_data(a_data), .o_serial_clk(a_sclk), .o_serial_latch(a_latch)
  );

  seg7_serial_chain #(
    .SYS_CLK_HZ(4), .SHIFT_CLK_HZ(1), .NUM_DIGITS(1),
    .MSB_FIRST(0), .LATCH_PERIODS(1), .INVERT_DATA(1)
  ) dut_b (
    .i_clk(clk), .i_reset(rst), .i_en(b_en), .i_start_stb(b_start),
    .i_frame(b_frame), .o_busy(b_busy), .o_done_stb(b_done),
    .o_serial_data(b_data), .o_serial_clk(b_sclk), .o_serial_latch(b_latch)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc;
  bit a_bits[$];
  bit b_bits[$];
  int a_done_q[$];
  int b_done_q[$];
  int a_lrise[$];
  int a_lfall[$];
  int a_busy_low;
  int a_clk_in_latch;
  logic a_sclk_q, a_latch_q, b_sclk_q;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_mon();
    cyc = 0;
    a_bits.delete(); b_bits.delete();
    a_done_q.delete(); b_done_q.delete();
    a_lrise.delete(); a_lfall.delete();
    a_busy_low = 0; a_clk_in_latch = 0;
    a_sclk_q = a_sclk; a_latch_q = a_latch; b_sclk_q = b_sclk;
  endtask

  // Advance one cycle and sample outputs mid-cycle.
  task automatic cycle();
    @(negedge clk);
    cyc++;
    if (a_sclk && !a_sclk_q) a_bits.push_back(a_data);
    if (b_sclk && !b_sclk_q) b_bits.push_back(b_data);
    if (a_latch && !a_latch_q) a_lrise.push_back(cyc);
    if (!a_latch && a_latch_q) a_lfall.push_back(cyc);
    if (a_done) a_done_q.push_back(cyc);
    if (b_done) b_done_q.push_back(cyc);
    if (!a_busy) a_busy_low++;
    if (a_sclk && a_latch) a_clk_in_latch++;
    a_sclk_q = a_sclk; a_latch_q = a_latch; b_sclk_q = b_sclk;
  endtask

  task automatic start_a(input logic [47:0] f);
    clr_mon();
    a_frame = f;
    a_start = 1'b1;
    cycle();
    a_start = 1'b0;
  endtask

  function automatic logic [47:0] pack_a(input int off);
    logic [47:0] w = '0;
    for (int i = 0; i < 48; i++) w = {w[46:0], a_bits[off+i]};
    return w;
  endfunction

  function automatic logic [7:0] pack_b();
    logic [7:0] w = '0;
    for (int i = 0; i < 8; i++) w = {w[6:0], b_bits[i]};
    return w;
  endfunction

  localparam logic [47:0] F0 = 48'hFF00_A53C_817E;
  localparam logic [47:0] FA = 48'h0123_4567_89AB;
  localparam logic [47:0] FB = 48'hDEAD_BEEF_0000;
  localparam logic [47:0] FC = 48'hF0F0_1234_5A5A;
  localparam logic [47:0] F2 = 48'h8000_0000_0001;

  initial begin
    rst = 1'b1; a_en = 1'b1; b_en = 1'b1;
    a_start = 1'b0; b_start = 1'b0; a_frame = '0; b_frame = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy",  {63'd0, a_busy},  64'd0);
    chk("rst_done",  {63'd0, a_done},  64'd0);
    chk("rst_sclk",  {63'd0, a_sclk},  64'd0);
    chk("rst_latch", {63'd0, a_latch}, 64'd0);
    chk("rst_data",  {63'd0, a_data},  64'd0);
    chk("rst_b_data_inv", {63'd0, b_data}, 64'd1);

    // Start coincident with reset is ignored.
    a_frame = FA; a_start = 1'b1;
    @(negedge clk);
    rst = 1'b0; a_start = 1'b0;
    clr_mon();
    repeat (6) cycle();
    chk("rst_start_busy", {63'd0, a_busy}, 64'd0);
    chk("rst_start_bits", 64'(a_bits.size()), 64'd0);
    $display("step: start during reset ignored");

    // Start with enable low is ignored.
    clr_mon();
    a_en = 1'b0; a_start = 1'b1;
    cycle();
    a_start = 1'b0; a_en = 1'b1;
    repeat (6) cycle();
    chk("en_low_busy_lows", 64'(a_busy_low), 64'd7);
    chk("en_low_bits", 64'(a_bits.size()), 64'd0);
    $display("step: start with enable low ignored");

    // Single frame, MSB first.
    start_a(F0);
    chk("single_busy_c1", {63'd0, a_busy}, 64'd1);
    chk("single_data_c1", {63'd0, a_data}, {63'd0, F0[47]});
    while (a_done_q.size() < 1 && cyc < 400) cycle();
    chk("single_done_cnt", 64'(a_done_q.size()), 64'd1);
    chk("single_done_cyc", 64'(a_done_q[0]), 64'd197);
    chk("single_nbits", 64'(a_bits.size()), 64'd48);
    chk("single_bits", {16'd0, pack_a(0)}, {16'd0, F0});
    chk("single_lrise", 64'(a_lrise[0]), 64'd193);
    chk("single_lfall", 64'(a_lfall[0]), 64'd197);
    chk("single_busy_done", {63'd0, a_busy}, 64'd0);
    $display("frame single: %h done at cycle %0d", F0, a_done_q[0]);
    repeat (3) cycle();

    // LSB-first inverted one-digit chain.
    clr_mon();
    b_frame = 8'h01; b_start = 1'b1;
    cycle();
    b_start = 1'b0;
    chk("lsb_data_c1", {63'd0, b_data}, 64'd0);
    while (b_done_q.size() < 1 && cyc < 200) cycle();
    chk("lsb_done_cyc", 64'(b_done_q[0]), 64'd37);
    chk("lsb_nbits", 64'(b_bits.size()), 64'd8);
    chk("lsb_bits", {56'd0, pack_b()}, 64'h7F);
    chk("lsb_idle_data", {63'd0, b_data}, 64'd1);
    $display("frame lsb_inv: 01 done at cycle %0d", b_done_q[0]);
    repeat (3) cycle();

    // Pending buffer, last start wins.
    start_a(FA);
    while (cyc < 10) cycle();
    a_frame = FB; a_start = 1'b1; cycle(); a_start = 1'b0;
    while (cyc < 100) cycle();
    a_frame = FC; a_start = 1'b1; cycle(); a_start = 1'b0;
    while (a_done_q.size() < 2 && cyc < 800) cycle();
    chk("pend_done_cnt", 64'(a_done_q.size()), 64'd2);
    chk("pend_done0", 64'(a_done_q[0]), 64'd197);
    chk("pend_done1", 64'(a_done_q[1]), 64'd393);
    chk("pend_nbits", 64'(a_bits.size()), 64'd96);
    chk("pend_bits_a", {16'd0, pack_a(0)}, {16'd0, FA});
    chk("pend_bits_c", {16'd0, pack_a(48)}, {16'd0, FC});
    chk("pend_busy_lows", 64'(a_busy_low), 64'd1);
    $display("frame pending: %h then %h done at cycles %0d %0d", FA, FC, a_done_q[0], a_done_q[1]);
    repeat (3) cycle();

    // Abort mid-frame.
    start_a(F0);
    while (a_bits.size() < 20 && cyc < 400) cycle();
    a_en = 1'b0;
    cycle();
    chk("abort_sclk",  {63'd0, a_sclk},  64'd0);
    chk("abort_latch", {63'd0, a_latch}, 64'd0);
    chk("abort_busy",  {63'd0, a_busy},  64'd0);
    chk("abort_data",  {63'd0, a_data},  64'd0);
    a_en = 1'b1;
    repeat (300) cycle();
    chk("abort_no_done",  64'(a_done_q.size()), 64'd0);
    chk("abort_no_latch", 64'(a_lrise.size()),  64'd0);
    $display("frame abort: stopped after %0d bits", a_bits.size());
    start_a(F2);
    while (a_done_q.size() < 1 && cyc < 400) cycle();
    chk("after_abort_done", 64'(a_done_q[0]), 64'd197);
    chk("after_abort_bits", {16'd0, pack_a(0)}, {16'd0, F2});
    $display("frame after_abort: %h done at cycle %0d", F2, a_done_q[0]);

    // Back-to-back: restart in the done cycle.
    repeat (2) cycle();
    start_a(FC);
    while (a_done_q.size() < 1 && cyc < 400) cycle();
    a_frame = F0; a_start = 1'b1; cycle(); a_start = 1'b0;
    chk("b2b_busy_next", {63'd0, a_busy}, 64'd1);
    chk("b2b_data_next", {63'd0, a_data}, {63'd0, F0[47]});
    while (a_done_q.size() < 2 && cyc < 800) cycle();
    chk("b2b_done1", 64'(a_done_q[1]), 64'd394);
    chk("b2b_lrise1", 64'(a_lrise[1]), 64'd390);
    chk("b2b_lfall0", 64'(a_lfall[0]), 64'd197);
    chk("b2b_busy_lows", 64'(a_busy_low), 64'd2);
    chk("b2b_bits0", {16'd0, pack_a(0)}, {16'd0, FC});
    chk("b2b_bits1", {16'd0, pack_a(48)}, {16'd0, F0});
    chk("b2b_clk_in_latch", 64'(a_clk_in_latch), 64'd0);
    $display("frame b2b: %h then %h done at cycles %0d %0d", FC, F0, a_done_q[0], a_done_q[1]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
